// File: rtl/sprite_animator_if.sv
// ---------------------------------------------------------------------------
// sprite_animator_if
//   Groups the video-timing inputs, the sprite controls, the ROM port and the
//   pixel outputs of sprite_animator.
//   master : raster/controller side. It drives DrawX, DrawY, blank, vs,
//            sprite_x, sprite_y, flip, walking and rom_q. It receives
//            rom_address, pix_idx, pix_on and frame_num.
//   slave  : sprite_animator itself, with the opposite directions.
// ---------------------------------------------------------------------------
interface sprite_animator_if #(
  parameter int IDX_W   = 2,
  parameter int ADDR_W  = 8,
  parameter int FRAME_W = 2
);
  logic [9:0]         DrawX;
  logic [9:0]         DrawY;
  logic               blank;
  logic               vs;
  logic [9:0]         sprite_x;
  logic [9:0]         sprite_y;
  logic               flip;
  logic               walking;
  logic [ADDR_W-1:0]  rom_address;
  logic [IDX_W-1:0]   rom_q;
  logic [IDX_W-1:0]   pix_idx;
  logic               pix_on;
  logic [FRAME_W-1:0] frame_num;

  modport master (
    output DrawX, DrawY, blank, vs, sprite_x, sprite_y, flip, walking, rom_q,
    input  rom_address, pix_idx, pix_on, frame_num
  );

  modport slave (
    input  DrawX, DrawY, blank, vs, sprite_x, sprite_y, flip, walking, rom_q,
    output rom_address, pix_idx, pix_on, frame_num
  );
endinterface

// File: rtl/sprite_animator.sv
// ---------------------------------------------------------------------------
// sprite_animator
//   This block is a positioned, scaled and animated sprite pixel source.
//   - A pixel enters at cycle N. The ROM address is registered at N+1.
//   - The ROM returns data at N+2.
//   - pix_idx and pix_on are registered at N+3.
//   - The block accepts one pixel per clock.
//   Position, flip and the animation frame change only at the falling edge
//   of vs, so the sprite never tears partway through a frame.
// Ports
//   vga_clk : pixel clock
//   reset   : asynchronous reset, active high
//   bus     : sprite_animator_if.slave
//     inputs  : DrawX, DrawY, blank, vs, sprite_x, sprite_y, flip, walking,
//               rom_q
//     outputs : rom_address, pix_idx, pix_on, frame_num
// ---------------------------------------------------------------------------
module sprite_animator #(
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16,
  parameter int NUM_FRAMES  = 4,
  parameter int SCALE_LOG2  = 1,
  parameter int IDX_W       = 2,
  parameter int FRAME_TICKS = 8,
  parameter int ADDR_W      = 8
) (
  input  logic              vga_clk,
  input  logic              reset,
  sprite_animator_if.slave  bus
);

  localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int COL_W   = $clog2(SPRITE_W);
  localparam int ROW_W   = $clog2(SPRITE_H);
  localparam int CNT_W   = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int FULL_W  = FRAME_W + ROW_W + COL_W;

  localparam logic [10:0]        BOX_W      = 11'(SPRITE_W << SCALE_LOG2);
  localparam logic [10:0]        BOX_H      = 11'(SPRITE_H << SCALE_LOG2);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [FRAME_W-1:0] FIRST_WALK = FRAME_W'(1);
  localparam logic [CNT_W-1:0]   LAST_TICK  = CNT_W'(FRAME_TICKS - 1);
  localparam logic [COL_W-1:0]   COL_MAX    = COL_W'(SPRITE_W - 1);

  typedef enum logic {ST_STAND, ST_WALK} state_t;

  // Frame boundary detection and per-frame latches.
  logic       vs_q;
  logic       vs_fall;
  logic [9:0] sx_q, sy_q;
  logic       flip_q;

  assign vs_fall = vs_q & ~bus.vs;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      vs_q   <= 1'b1;
      sx_q   <= '0;
      sy_q   <= '0;
      flip_q <= 1'b0;
    end else begin
      vs_q <= bus.vs;
      if (vs_fall) begin
        sx_q   <= bus.sprite_x;
        sy_q   <= bus.sprite_y;
        flip_q <= bus.flip;
      end
    end
  end

  // Animation FSM. It advances only on vs_fall.
  state_t             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_STAND;
      frame_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    if (vs_fall) begin
      case (state_q)
        ST_STAND: begin
          frame_d = '0;
          cnt_d   = '0;
          if (bus.walking) begin
            state_d = ST_WALK;
            frame_d = FIRST_WALK;
          end
        end
        ST_WALK: begin
          if (!bus.walking) begin
            state_d = ST_STAND;
            frame_d = '0;
            cnt_d   = '0;
          end else if (cnt_q == LAST_TICK) begin
            cnt_d = '0;
            // The walk cycle loops back to 1. Frame 0 is reserved for standing.
            frame_d = (frame_q == LAST_FRAME) ? FIRST_WALK
                                              : frame_q + FRAME_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_STAND;
          frame_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Stage 1: hit test and ROM address. The zero-extended 11-bit subtraction
  // wraps when the pixel is left of or above the sprite. The explicit >=
  // terms reject those cases, so a wrapped dx/dy can never produce a hit.
  logic [10:0]       dx, dy;
  logic              hit;
  logic [COL_W-1:0]  col, col_flip;
  logic [ROW_W-1:0]  row;
  logic [FULL_W-1:0] addr_full;
  logic [ADDR_W-1:0] rom_address_d;

  assign dx  = {1'b0, bus.DrawX} - {1'b0, sx_q};
  assign dy  = {1'b0, bus.DrawY} - {1'b0, sy_q};
  assign hit = bus.blank & (bus.DrawX >= sx_q) & (bus.DrawY >= sy_q) &
               (dx < BOX_W) & (dy < BOX_H);

  assign col      = dx[SCALE_LOG2 +: COL_W];
  assign row      = dy[SCALE_LOG2 +: ROW_W];
  assign col_flip = flip_q ? (COL_MAX - col) : col;
  // Power-of-two width and height make frame*W*H + row*W + col a plain
  // concatenation of the three fields.
  assign addr_full     = {frame_q, row, col_flip};
  assign rom_address_d = hit ? ADDR_W'(addr_full) : '0;

  logic [ADDR_W-1:0] rom_address_q;
  logic              hit_p1_q, hit_p2_q;
  logic [IDX_W-1:0]  pix_idx_q;
  logic              pix_on_q;
  logic              opaque_p2;

  assign opaque_p2 = hit_p2_q & (bus.rom_q != '0);

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rom_address_q <= '0;
      hit_p1_q      <= 1'b0;
      hit_p2_q      <= 1'b0;
      pix_idx_q     <= '0;
      pix_on_q      <= 1'b0;
    end else begin
      rom_address_q <= rom_address_d;
      hit_p1_q      <= hit;
      // Stage 2: ROM read in flight; the hit flag follows its data.
      hit_p2_q      <= hit_p1_q;
      // Stage 3: transparency; the index is forced to 0 when the pixel is off.
      pix_on_q      <= opaque_p2;
      pix_idx_q     <= opaque_p2 ? bus.rom_q : '0;
    end
  end

  assign bus.rom_address = rom_address_q;
  assign bus.pix_idx     = pix_idx_q;
  assign bus.pix_on      = pix_on_q;
  assign bus.frame_num   = frame_q;

endmodule

// File: tb/tb_sprite_animator.sv
module tb_sprite_animator;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sprite_animator_if #(.IDX_W(2), .ADDR_W(10), .FRAME_W(2)) bus ();

  sprite_animator #(
    .SPRITE_W(16), .SPRITE_H(16), .NUM_FRAMES(4), .SCALE_LOG2(1),
    .IDX_W(2), .FRAME_TICKS(8), .ADDR_W(10)
  ) dut (
    .vga_clk (clk),
    .reset   (reset),
    .bus     (bus)
  );

  // Synchronous ROM: contents are (addr % 3) + 1, never transparent unless overridden.
  logic       ovr_en = 1'b0;
  logic [1:0] ovr_val = 2'd0;

  function automatic logic [1:0] rom_f(input logic [9:0] a);
    return 2'((int'(a) % 3) + 1);
  endfunction

  always_ff @(posedge clk)
    bus.rom_q <= ovr_en ? ovr_val : rom_f(bus.rom_address);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vsync_pulse();
    bus.blank = 1'b0;
    bus.vs = 1'b0;
    step();
    bus.vs = 1'b1;
    step();
  endtask

  // One pixel held for three cycles: check address at N+1, index/flag at N+3.
  task automatic run_pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                         input logic [9:0] exp_addr, input logic exp_on,
                         input logic [1:0] exp_idx);
    bus.DrawX = x;
    bus.DrawY = y;
    step();
    chk({tag, "_addr"}, 32'(bus.rom_address), 32'(exp_addr));
    step();
    step();
    chk({tag, "_on"}, 32'(bus.pix_on), 32'(exp_on));
    chk({tag, "_idx"}, 32'(bus.pix_idx), 32'(exp_idx));
  endtask

  initial begin
    reset        = 1'b1;
    bus.DrawX    = '0;
    bus.DrawY    = '0;
    bus.blank    = 1'b0;
    bus.vs       = 1'b1;
    bus.sprite_x = 10'd100;
    bus.sprite_y = 10'd50;
    bus.flip     = 1'b0;
    bus.walking  = 1'b0;
    step();
    step();
    chk("rst_addr",  32'(bus.rom_address), 32'd0);
    chk("rst_on",    32'(bus.pix_on), 32'd0);
    chk("rst_idx",   32'(bus.pix_idx), 32'd0);
    chk("rst_frame", 32'(bus.frame_num), 32'd0);
    reset = 1'b0;
    step();

    // Basic position, scale x2, standing frame.
    vsync_pulse();
    chk("stand_frame", 32'(bus.frame_num), 32'd0);
    bus.blank = 1'b1;
    run_pix("tl",      10'd100, 10'd50, 10'd0,  1'b1, 2'd1);
    run_pix("right",   10'd131, 10'd50, 10'd15, 1'b1, 2'd1);
    run_pix("outx",    10'd132, 10'd50, 10'd0,  1'b0, 2'd0);
    run_pix("outy",    10'd100, 10'd49, 10'd0,  1'b0, 2'd0);
    run_pix("r1c1",    10'd102, 10'd53, 10'd17, 1'b1, 2'd3);

    // Back-to-back pixels, one per clock.
    bus.DrawY = 10'd50;
    bus.DrawX = 10'd100; step(); chk("st_a0", 32'(bus.rom_address), 32'd0);
    bus.DrawX = 10'd102; step(); chk("st_a1", 32'(bus.rom_address), 32'd1);
    bus.DrawX = 10'd104; step(); chk("st_a2", 32'(bus.rom_address), 32'd2);
    chk("st_i0", 32'(bus.pix_idx), 32'd1);
    step(); chk("st_i1", 32'(bus.pix_idx), 32'd2);
    step(); chk("st_i2", 32'(bus.pix_idx), 32'd3);

    // The flip input is ignored until the next vs falling edge, then mirrors.
    bus.flip = 1'b1;
    run_pix("flip_pre", 10'd100, 10'd52, 10'd16, 1'b1, 2'd2);
    vsync_pulse();
    bus.blank = 1'b1;
    run_pix("flip_l", 10'd100, 10'd52, 10'd31, 1'b1, 2'd2);
    run_pix("flip_r", 10'd131, 10'd52, 10'd16, 1'b1, 2'd2);

    // Transparency from ROM data.
    ovr_en = 1'b1; ovr_val = 2'd0;
    run_pix("transp", 10'd100, 10'd52, 10'd31, 1'b0, 2'd0);
    ovr_val = 2'd3;
    run_pix("opaque", 10'd100, 10'd52, 10'd31, 1'b1, 2'd3);
    ovr_en = 1'b0;

    // Walk cycle.
    bus.flip = 1'b0;
    bus.walking = 1'b1;
    vsync_pulse();
    chk("walk_f1", 32'(bus.frame_num), 32'd1);
    for (int i = 2; i <= 8; i++) vsync_pulse();
    chk("walk_f8", 32'(bus.frame_num), 32'd1);
    vsync_pulse();
    chk("walk_f9", 32'(bus.frame_num), 32'd2);
    for (int i = 10; i <= 17; i++) vsync_pulse();
    chk("walk_f17", 32'(bus.frame_num), 32'd3);
    for (int i = 18; i <= 25; i++) vsync_pulse();
    chk("walk_f25", 32'(bus.frame_num), 32'd1);
    bus.blank = 1'b1;
    run_pix("f1base", 10'd100, 10'd50, 10'd256, 1'b1, 2'd2);
    bus.walking = 1'b0;
    vsync_pulse();
    chk("stop_f0", 32'(bus.frame_num), 32'd0);
    bus.blank = 1'b1;
    run_pix("f0base", 10'd100, 10'd50, 10'd0, 1'b1, 2'd1);

    // Screen edge: no wrap-around.
    bus.sprite_x = 10'd630;
    bus.sprite_y = 10'd470;
    vsync_pulse();
    bus.blank = 1'b1;
    run_pix("edge_tl", 10'd630, 10'd470, 10'd0,  1'b1, 2'd1);
    run_pix("edge_br", 10'd639, 10'd479, 10'd68, 1'b1, 2'd3);
    run_pix("nowrapx", 10'd0,   10'd470, 10'd0,  1'b0, 2'd0);
    run_pix("nowrapy", 10'd639, 10'd0,   10'd0,  1'b0, 2'd0);
    bus.blank = 1'b0;
    run_pix("blanked", 10'd630, 10'd470, 10'd0,  1'b0, 2'd0);
    bus.blank = 1'b1;
    bus.sprite_x = 10'd100;
    run_pix("midfr_old", 10'd630, 10'd470, 10'd0, 1'b1, 2'd1);
    run_pix("midfr_new", 10'd100, 10'd470, 10'd0, 1'b0, 2'd0);

    // Reset with a hit pixel in flight and a walking frame displayed.
    bus.sprite_x = 10'd630;
    bus.walking = 1'b1;
    vsync_pulse();
    chk("pre_rst_frame", 32'(bus.frame_num), 32'd1);
    bus.blank = 1'b1;
    bus.DrawX = 10'd630;
    bus.DrawY = 10'd470;
    step();
    step();
    step();
    chk("pre_rst_on", 32'(bus.pix_on), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_on", 32'(bus.pix_on), 32'd0);
    chk("rst_mid_frame", 32'(bus.frame_num), 32'd0);
    step();
    reset = 1'b0;
    bus.sprite_x = 10'd100;
    bus.walking = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_on", 32'(bus.pix_on), 32'd0);
    end
    vsync_pulse();
    chk("post_rst_frame", 32'(bus.frame_num), 32'd0);
    bus.blank = 1'b1;
    run_pix("post_rst_hit", 10'd100, 10'd470, 10'd0, 1'b1, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
